// File: rtl/output_argmax.sv
// -----------------------------------------------------------------------------
// output_argmax
//
// Picks the index and value of the largest signed neuron output of a network's
// final layer. A whole vector is captured in one cycle, then scanned one element
// per cycle, so one result is produced every NN cycles.
//
// Ports:
//   clk      - sole clock, rising-edge active
//   rst      - asynchronous active-low reset
//   i_valid  - per-neuron valid vector; only bit 0 starts a capture
//   i_data   - packed neuron values, element n at [n*dataWidth +: dataWidth]
//   o_busy   - high while a captured vector is being scanned
//   o_valid  - one-cycle pulse marking a new result on o_index/o_max
//   o_index  - index of the maximum element of the last completed vector
//   o_max    - value of that maximum element
//   o_drop   - one-cycle pulse when a vector arrives during a scan and is lost
// -----------------------------------------------------------------------------
module output_argmax #(
    parameter int NN        = 10,
    parameter int dataWidth = 16,
    parameter int idxWidth  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic [idxWidth-1:0]     o_index,
    output logic [dataWidth-1:0]    o_max,
    output logic                    o_drop
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(NN - 1);

    logic [0:0]                  state_q,  state_d;
    logic [idxWidth-1:0]         cnt_q,    cnt_d;
    logic signed [dataWidth-1:0] runMax_q, runMax_d;
    logic [idxWidth-1:0]         runIdx_q, runIdx_d;
    logic [idxWidth-1:0]         index_q,  index_d;
    logic [dataWidth-1:0]        max_q,    max_d;
    logic                        valid_q,  valid_d;
    logic                        drop_q,   drop_d;
    logic                        load;

    logic signed [dataWidth-1:0] buf_q [NN];

    logic signed [dataWidth-1:0] curElem;
    logic signed [dataWidth-1:0] candMax;
    logic [idxWidth-1:0]         candIdx;

    // Only bit 0 of the valid vector carries meaning; the rest are folded
    // into a deliberately unused net so they are visibly accounted for.
    logic unusedValidBits;
    assign unusedValidBits = ^i_valid[NN-1:1];

    // Select the buffered element addressed by the scan counter.
    always_comb begin
        curElem = '0;
        for (int n = 0; n < NN; n++) begin
            if (cnt_q == idxWidth'(n)) begin
                curElem = buf_q[n];
            end
        end
    end

    // Only a strictly greater element replaces the running max, which makes
    // ties resolve to the lowest index.
    always_comb begin
        candMax = runMax_q;
        candIdx = runIdx_q;
        if (curElem > runMax_q) begin
            candMax = curElem;
            candIdx = cnt_q;
        end
    end

    // Next-state logic. The edge that handles the last element publishes the
    // result directly from the candidate, so the running registers need not be
    // updated on that edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        runMax_d = runMax_q;
        runIdx_d = runIdx_q;
        index_d  = index_q;
        max_d    = max_q;
        valid_d  = 1'b0;
        drop_d   = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid[0]) begin
                    load     = 1'b1;
                    runMax_d = i_data[dataWidth-1:0];
                    runIdx_d = '0;
                    cnt_d    = idxWidth'(1);
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (i_valid[0]) begin
                    drop_d = 1'b1;
                end
                if (cnt_q == LAST_IDX) begin
                    index_d = candIdx;
                    max_d   = candMax;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    runMax_d = candMax;
                    runIdx_d = candIdx;
                    cnt_d    = cnt_q + idxWidth'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; the buffer is only written on a capture edge so input
    // changes during a scan cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            runMax_q <= '0;
            runIdx_q <= '0;
            index_q  <= '0;
            max_q    <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                buf_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            runMax_q <= runMax_d;
            runIdx_q <= runIdx_d;
            index_q  <= index_d;
            max_q    <= max_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            if (load) begin
                for (int n = 0; n < NN; n++) begin
                    buf_q[n] <= i_data[n*dataWidth +: dataWidth];
                end
            end
        end
    end

    assign o_busy  = (state_q == SCAN);
    assign o_valid = valid_q;
    assign o_index = index_q;
    assign o_max   = max_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_output_argmax.sv
// -----------------------------------------------------------------------------
// tb_output_argmax
//
// Self-checking bench for output_argmax with NN=10, 16-bit data. Each scenario
// task drives its own stimulus and compares against a behavioural argmax
// model computed over a plain array.
// -----------------------------------------------------------------------------
module tb_output_argmax;

    localparam int NN = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic              clk;
    logic              rst;
    logic [NN-1:0]     i_valid;
    logic [NN*DW-1:0]  i_data;
    logic              o_busy;
    logic              o_valid;
    logic [IW-1:0]     o_index;
    logic [DW-1:0]     o_max;
    logic              o_drop;

    int checks;
    int errors;

    logic [DW-1:0] vecArr [NN];

    output_argmax #(.NN(NN), .dataWidth(DW), .idxWidth(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_index (o_index),
        .o_max   (o_max),
        .o_drop  (o_drop)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: argmax over signed values, first occurrence wins.
    task automatic modelArgmax(output int expIdx, output logic [DW-1:0] expMax);
        int best;
        best = 0;
        for (int n = 1; n < NN; n++) begin
            if ($signed(vecArr[n]) > $signed(vecArr[best])) best = n;
        end
        expIdx = best;
        expMax = vecArr[best];
    endtask

    task automatic loadData();
        for (int n = 0; n < NN; n++) i_data[n*DW +: DW] = vecArr[n];
    endtask

    // Present vecArr with a one-cycle valid pulse; returns #1 after capture edge.
    task automatic driveVector();
        loadData();
        i_valid = '0;
        i_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        i_valid = '0;
    endtask

    // Count edges from capture until o_valid, and cycles with o_busy high.
    task automatic waitResult(output int edges, output int busyCnt, output bit seen);
        edges = 0;
        busyCnt = 0;
        seen = 0;
        if (o_busy) busyCnt++;
        while (!seen && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
            if (o_valid) seen = 1;
            else if (o_busy) busyCnt++;
        end
    endtask

    task automatic randomVector(input bit tiny);
        for (int n = 0; n < NN; n++) begin
            if (tiny) vecArr[n] = DW'($urandom_range(0, 3)) - DW'(1);
            else vecArr[n] = DW'($urandom);
        end
    endtask

    task automatic test_reset();
        int edges, busyCnt, expIdx;
        bit seen;
        logic [DW-1:0] expMax;
        rst = 1'b0;
        i_valid = '0;
        i_data = '0;
        #2;
        checks++;
        if ({o_busy, o_valid, o_drop, o_index, o_max} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got busy=%0b valid=%0b drop=%0b idx=%0d max=%h want all 0",
                     o_busy, o_valid, o_drop, o_index, o_max);
        end
        i_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_valid = '0;
        checks++;
        if ({o_busy, o_valid, o_drop, o_index, o_max} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held: got busy=%0b valid=%0b drop=%0b idx=%0d max=%h want all 0",
                     o_busy, o_valid, o_drop, o_index, o_max);
        end
        rst = 1'b1;
        randomVector(0);
        modelArgmax(expIdx, expMax);
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || edges != 9 || o_index !== IW'(expIdx) || o_max !== expMax) begin
            errors++;
            $display("[TB] FAIL first_capture: got seen=%0b edges=%0d idx=%0d max=%h want edges=9 idx=%0d max=%h",
                     seen, edges, o_index, o_max, expIdx, expMax);
        end
    endtask

    task automatic test_ramp();
        int edges, busyCnt;
        bit seen;
        for (int n = 0; n < NN; n++) vecArr[n] = DW'(16'h10 * (n + 1));
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || edges != 9) begin
            errors++;
            $display("[TB] FAIL ramp_latency: got seen=%0b edges=%0d want edges=9", seen, edges);
        end
        checks++;
        if (o_index !== 4'd9 || o_max !== 16'h00A0) begin
            errors++;
            $display("[TB] FAIL ramp_result: got idx=%0d max=%h want idx=9 max=00a0", o_index, o_max);
        end
        checks++;
        if (busyCnt != 9) begin
            errors++;
            $display("[TB] FAIL ramp_busy: got %0d busy cycles want 9", busyCnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_index !== 4'd9) begin
            errors++;
            $display("[TB] FAIL ramp_pulse: got valid=%0b busy=%0b idx=%0d want valid=0 busy=0 idx=9",
                     o_valid, o_busy, o_index);
        end
    endtask

    task automatic test_signed();
        int edges, busyCnt;
        bit seen;
        for (int n = 0; n < NN; n++) vecArr[n] = 16'h8000;
        vecArr[3] = 16'h7FFF;
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || o_index !== 4'd3 || o_max !== 16'h7FFF) begin
            errors++;
            $display("[TB] FAIL signed_extreme: got seen=%0b idx=%0d max=%h want idx=3 max=7fff",
                     seen, o_index, o_max);
        end
        for (int n = 0; n < NN; n++) vecArr[n] = 16'hFFFE;
        vecArr[6] = 16'hFFFF;
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || o_index !== 4'd6 || o_max !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL signed_negative: got seen=%0b idx=%0d max=%h want idx=6 max=ffff",
                     seen, o_index, o_max);
        end
    endtask

    task automatic test_tie();
        int edges, busyCnt;
        bit seen;
        for (int n = 0; n < NN; n++) vecArr[n] = 16'h0000;
        vecArr[2] = 16'h0100;
        vecArr[7] = 16'h0100;
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || o_index !== 4'd2 || o_max !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL tie_lowest: got seen=%0b idx=%0d max=%h want idx=2 max=0100",
                     seen, o_index, o_max);
        end
    endtask

    task automatic test_back_to_back();
        int edges, busyCnt, expIdx;
        bit seen;
        logic [DW-1:0] expMax;
        randomVector(0);
        modelArgmax(expIdx, expMax);
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || o_index !== IW'(expIdx) || o_max !== expMax) begin
            errors++;
            $display("[TB] FAIL b2b_first: got seen=%0b idx=%0d max=%h want idx=%0d max=%h",
                     seen, o_index, o_max, expIdx, expMax);
        end
        for (int n = 0; n < NN; n++) vecArr[n] = DW'($urandom_range(0, 16'h4F));
        vecArr[4] = 16'h0050;
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || edges != 9 || o_index !== 4'd4 || o_max !== 16'h0050) begin
            errors++;
            $display("[TB] FAIL b2b_second: got seen=%0b edges=%0d idx=%0d max=%h want edges=9 idx=4 max=0050",
                     seen, edges, o_index, o_max);
        end
    endtask

    task automatic test_overlap();
        int expIdx, drops, valids;
        logic [DW-1:0] expMax;
        randomVector(0);
        modelArgmax(expIdx, expMax);
        driveVector();
        drops = 0;
        valids = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (o_drop) drops++;
            if (o_valid) valids++;
            i_valid = '0;
            if (e == 3) i_valid[0] = 1'b1;
            if (e < 9) i_data = {NN{DW'($urandom)}};
        end
        checks++;
        if (drops != 1) begin
            errors++;
            $display("[TB] FAIL overlap_drop: got %0d drop pulses want 1", drops);
        end
        checks++;
        if (valids != 1) begin
            errors++;
            $display("[TB] FAIL overlap_valid: got %0d valid pulses want 1", valids);
        end
        checks++;
        if (o_index !== IW'(expIdx) || o_max !== expMax) begin
            errors++;
            $display("[TB] FAIL overlap_result: got idx=%0d max=%h want idx=%0d max=%h",
                     o_index, o_max, expIdx, expMax);
        end
    endtask

    task automatic test_reset_midscan();
        int edges, busyCnt, expIdx, valids;
        bit seen;
        logic [DW-1:0] expMax;
        randomVector(0);
        driveVector();
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_valid, o_drop, o_index, o_max} !== '0) begin
            errors++;
            $display("[TB] FAIL midscan_async: got busy=%0b valid=%0b drop=%0b idx=%0d max=%h want all 0",
                     o_busy, o_valid, o_drop, o_index, o_max);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_valid, o_drop, o_index, o_max} !== '0) begin
            errors++;
            $display("[TB] FAIL midscan_held: got busy=%0b valid=%0b drop=%0b idx=%0d max=%h want all 0",
                     o_busy, o_valid, o_drop, o_index, o_max);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        valids = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (o_valid) valids++;
        end
        checks++;
        if (valids != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midscan_abandon: got %0d valid pulses busy=%0b want 0 and 0", valids, o_busy);
        end
        randomVector(0);
        modelArgmax(expIdx, expMax);
        driveVector();
        waitResult(edges, busyCnt, seen);
        checks++;
        if (!seen || edges != 9 || o_index !== IW'(expIdx) || o_max !== expMax) begin
            errors++;
            $display("[TB] FAIL midscan_fresh: got seen=%0b edges=%0d idx=%0d max=%h want edges=9 idx=%0d max=%h",
                     seen, edges, o_index, o_max, expIdx, expMax);
        end
    endtask

    task automatic test_random();
        int edges, busyCnt, expIdx;
        bit seen;
        logic [DW-1:0] expMax;
        for (int t = 0; t < 24; t++) begin
            randomVector(t[0]);
            modelArgmax(expIdx, expMax);
            driveVector();
            waitResult(edges, busyCnt, seen);
            checks++;
            if (!seen || edges != 9 || o_index !== IW'(expIdx) || o_max !== expMax) begin
                errors++;
                $display("[TB] FAIL random_%0d: got seen=%0b edges=%0d idx=%0d max=%h want edges=9 idx=%0d max=%h",
                         t, seen, edges, o_index, o_max, expIdx, expMax);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ramp();
        test_signed();
        test_tie();
        test_back_to_back();
        test_overlap();
        test_reset_midscan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_argmax.md
OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 Parameter NN, default 10, number of neuron values per result vector; SHALL be >= 2.
REQ-002 Parameter dataWidth, default 16, width of each signed two's-complement neuron value.
REQ-003 Parameter idxWidth, default 4, width of the index output; SHALL satisfy 2^idxWidth >= NN.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low; asserted (0) clears all state immediately.
REQ-006 i_valid  input  NN  per-neuron valid vector from the output layer; only bit 0 is sampled.
REQ-007 i_data  input  NN*dataWidth  packed neuron values; element n at bits [n*dataWidth +: dataWidth].
REQ-008 o_busy  output  1  high while a captured vector is being scanned.
REQ-009 o_valid  output  1  one-cycle pulse marking a new result.
REQ-010 o_index  output  idxWidth  index of the maximum element of the last completed vector.
REQ-011 o_max  output  dataWidth  value of that maximum element.
REQ-012 o_drop  output  1  one-cycle pulse when an input vector is discarded.

Function
REQ-013 FSM states: IDLE and SCAN only.
REQ-014 IDLE with i_valid[0]=1 at a rising edge: all NN elements are copied into an internal buffer, running max = element 0, running index = 0, counter = 1, state -> SCAN.
- o_busy SHALL be 1 from the following cycle.
REQ-015 SCAN, each rising edge: compare buffer[counter] against the running max as signed dataWidth values.
- Strictly greater: running max and index take that element and counter.
- Equal or smaller: running max and index are unchanged, so ties resolve to the lowest index.
- Counter then increments.
REQ-016 The edge that processes counter = NN-1 SHALL also:
- load o_index and o_max with the final result;
- set o_valid = 1 for exactly one cycle;
- return the state to IDLE and clear o_busy.
REQ-017 Latency: if the capture edge is edge k, o_valid SHALL be high in the cycle after edge k+NN-1 (9 edges after capture for NN=10).
REQ-018 Throughput: a new capture SHALL be accepted on the edge immediately after o_valid rises, giving one vector per NN cycles.
REQ-019 i_valid[0]=1 while in SCAN: the vector SHALL be ignored, the scan SHALL be unaffected, and o_drop SHALL pulse for one cycle.
REQ-020 The buffer SHALL be written only on a capture edge; i_data changes during SCAN SHALL have no effect.
REQ-021 o_index and o_max SHALL hold their values until the next o_valid.
REQ-022 No arithmetic widening: the comparison is a pure signed compare, with no saturation and no wrap.

Reset
REQ-023 While rst=0, the following SHALL be forced immediately, regardless of clk:
- state = IDLE; counter = 0; buffer = 0;
- o_busy = 0, o_valid = 0, o_drop = 0, o_index = 0, o_max = 0.
REQ-024 Reset asserted mid-SCAN SHALL abandon the scan; no o_valid SHALL follow for that vector.
REQ-025 On the first rising edge after rst deasserts, the block SHALL be in IDLE and able to capture.

Verification
REQ-026 NN=10, data = {0x0010, 0x0020, ..., 0x00A0} (element n = 0x10*(n+1)), one-cycle i_valid[0] pulse -> o_valid once, 9 edges after capture; o_index=9; o_max=0x00A0; o_busy high for 9 cycles.
REQ-027 Signed check: element 3 = 0x7FFF, all others 0x8000 -> o_index=3, o_max=0x7FFF; all elements 0xFFFE except element 6 = 0xFFFF -> o_index=6, o_max=0xFFFF.
REQ-028 Tie rule: elements 2 and 7 both 0x0100, all others 0x0000 -> o_index=2, o_max=0x0100.
REQ-029 Back-to-back vectors: second i_valid pulse on the edge after o_valid; second vector has max 0x0050 at index 4 -> second o_valid 9 edges later, o_index=4.
REQ-030 Overlap and stability: i_valid[0] pulsed 3 cycles into SCAN, and i_data changed during SCAN -> o_drop pulses once; the first result is unchanged; no extra o_valid.
REQ-031 Reset mid-scan: rst=0 for 2 cycles at scan cycle 5 -> all outputs read 0 while rst=0, regardless of clk; no o_valid follows; a fresh vector afterwards completes normally.
